traffic_phase_timer: RTL and testbench



---
 rtl/traffic_phase_timer_if.sv | 30 +++
 rtl/traffic_phase_timer.sv | 114 +++++++++++
 tb/tb_traffic_phase_timer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_timer_if.sv
// Bundle between the traffic-light FSM (master) and its phase timer (slave).
// The FSM drives phase and the pedestrian button; the timer returns its strobe and status.
interface traffic_phase_timer_if #(
  parameter int COUNT_W = 8
);
  logic [1:0]         phase;
  logic               ped_req;
  logic               advance;
  logic [COUNT_W-1:0] remaining;
  logic               ped_pending;
  logic               walk;

  modport master (
    output phase,
    output ped_req,
    input  advance,
    input  remaining,
    input  ped_pending,
    input  walk
  );

  modport slave (
    input  phase,
    input  ped_req,
    output advance,
    output remaining,
    output ped_pending,
    output walk
  );
endinterface

// File: rtl/traffic_phase_timer.sv
// Per-phase dwell timer for the traffic-light FSM: issues a one-cycle advance strobe and tracks pedestrian requests.
// Optional macro PED_SHORTEN_EN caps the green countdown while a pedestrian request is waiting.
module traffic_phase_timer #(
  parameter int COUNT_W       = 8,
  parameter int GREEN_TIME    = 8,
  parameter int YELLOW_TIME   = 3,
  parameter int RED_TIME      = 6,
  parameter int PED_GREEN_CAP = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  traffic_phase_timer_if.slave tpt
);

  typedef enum logic [1:0] {
    PH_GREEN   = 2'b00,
    PH_YELLOW  = 2'b01,
    PH_RED     = 2'b10,
    PH_ILLEGAL = 2'b11
  } phase_t;

`ifdef PED_SHORTEN_EN
  localparam bit SHORTEN_EN = 1'b1;
`else
  localparam bit SHORTEN_EN = 1'b0;
`endif

  localparam logic [COUNT_W-1:0] GREEN_LOAD  = COUNT_W'(GREEN_TIME - 1);
  localparam logic [COUNT_W-1:0] YELLOW_LOAD = COUNT_W'(YELLOW_TIME - 1);
  localparam logic [COUNT_W-1:0] RED_LOAD    = COUNT_W'(RED_TIME - 1);
  localparam logic [COUNT_W-1:0] CAP_VAL     = COUNT_W'(PED_GREEN_CAP);

  phase_t             phase_in;
  phase_t             phase_q;
  logic [COUNT_W-1:0] remaining_q;
  logic [COUNT_W-1:0] load_val;
  logic               done;
  logic               advance_q;
  logic               ped_pending_q;
  logic               walk_q;
  logic               ped_sync1;
  logic               ped_sync2;
  logic               ped_sync_d;
  logic               ped_rise;

  assign phase_in = phase_t'(tpt.phase);
  assign ped_rise = ped_sync2 & ~ped_sync_d;

  // Illegal phase loads zero so a recovery strobe follows on the very next edge.
  always_comb begin
    load_val = '0;
    case (phase_in)
      PH_GREEN:  load_val = GREEN_LOAD;
      PH_YELLOW: load_val = YELLOW_LOAD;
      PH_RED:    load_val = RED_LOAD;
      default:   load_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q       <= PH_RED;
      remaining_q   <= RED_LOAD;
      done          <= 1'b0;
      advance_q     <= 1'b0;
      ped_pending_q <= 1'b0;
      walk_q        <= 1'b0;
      ped_sync1     <= 1'b0;
      ped_sync2     <= 1'b0;
      ped_sync_d    <= 1'b0;
    end else begin
      ped_sync1  <= tpt.ped_req;
      ped_sync2  <= ped_sync1;
      ped_sync_d <= ped_sync2;

      if (phase_in != phase_q) begin
        phase_q     <= phase_in;
        done        <= 1'b0;
        advance_q   <= 1'b0;
        remaining_q <= load_val;
        // Entering red serves any request, including one rising on this same edge.
        if (phase_in == PH_RED) begin
          walk_q        <= ped_pending_q | ped_rise;
          ped_pending_q <= 1'b0;
        end else begin
          ped_pending_q <= ped_pending_q | ped_rise;
          if (phase_q == PH_RED)
            walk_q <= 1'b0;
        end
      end else begin
        ped_pending_q <= ped_pending_q | ped_rise;
        if (SHORTEN_EN && (phase_q == PH_GREEN) && (ped_pending_q | ped_rise) &&
            (remaining_q > CAP_VAL)) begin
          remaining_q <= CAP_VAL;
          advance_q   <= 1'b0;
        end else if (remaining_q != '0) begin
          remaining_q <= remaining_q - COUNT_W'(1);
          advance_q   <= 1'b0;
        end else if (!done) begin
          advance_q <= 1'b1;
          done      <= 1'b1;
        end else begin
          advance_q <= 1'b0;
        end
      end
    end
  end

  assign tpt.advance     = advance_q;
  assign tpt.remaining   = remaining_q;
  assign tpt.ped_pending = ped_pending_q;
  assign tpt.walk        = walk_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Randomized bench for traffic_phase_timer: the bench plays the traffic FSM and compares every cycle
// against a timestamp-based model (each phase records the edge at which its countdown reaches zero).
module tb_traffic_phase_timer;

  localparam int COUNT_W       = 8;
  localparam int GREEN_TIME    = 8;
  localparam int YELLOW_TIME   = 3;
  localparam int RED_TIME      = 6;
  localparam int PED_GREEN_CAP = 2;
  localparam int NUM_CYCLES    = 3000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  traffic_phase_timer_if #(.COUNT_W(COUNT_W)) tpt ();

  traffic_phase_timer #(
    .COUNT_W      (COUNT_W),
    .GREEN_TIME   (GREEN_TIME),
    .YELLOW_TIME  (YELLOW_TIME),
    .RED_TIME     (RED_TIME),
    .PED_GREEN_CAP(PED_GREEN_CAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tpt(tpt)
  );

  int checks = 0;
  int errors = 0;

  // Model state: zero_at is the edge number after which the countdown reads zero.
  int       edge_num;
  int       zero_at;
  bit       strobed;
  bit       m_adv;
  bit       m_pending;
  bit       m_walk;
  bit [1:0] m_phase_q;
  bit       ped_d1, ped_d2, ped_d3;

  bit [1:0] fsm_phase;
  bit       prev_adv;
  int       force_cnt;
  int       ped_cnt;
  bit       first_seen;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int dwell(input bit [1:0] ph);
    case (ph)
      2'b00:   return GREEN_TIME;
      2'b01:   return YELLOW_TIME;
      2'b10:   return RED_TIME;
      default: return 1;
    endcase
  endfunction

  function automatic int rem_at(input int e);
    return (zero_at > e) ? (zero_at - e) : 0;
  endfunction

  function automatic bit [1:0] next_phase(input bit [1:0] ph);
    case (ph)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      2'b10:   return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_reset();
    m_phase_q = 2'b10;
    zero_at   = edge_num + RED_TIME - 1;
    strobed   = 1'b0;
    m_adv     = 1'b0;
    m_pending = 1'b0;
    m_walk    = 1'b0;
    ped_d1    = 1'b0;
    ped_d2    = 1'b0;
    ped_d3    = 1'b0;
  endtask

  // A button rise is seen two edges after it is sampled (two sync stages, then edge detect).
  task automatic model_step(input bit [1:0] ph, input bit ped);
    int e;
    int pre;
    bit rise;
    bit want;
    edge_num++;
    e    = edge_num;
    pre  = rem_at(e - 1);
    rise = ped_d2 & ~ped_d3;
    want = m_pending | rise;
    m_adv = 1'b0;
    if (ph != m_phase_q) begin
      if (ph == 2'b10) begin
        m_walk    = want;
        m_pending = 1'b0;
      end else begin
        m_pending = want;
        if (m_phase_q == 2'b10) m_walk = 1'b0;
      end
      m_phase_q = ph;
      zero_at   = e + dwell(ph) - 1;
      strobed   = 1'b0;
    end else begin
      m_pending = want;
`ifdef PED_SHORTEN_EN
      if (m_phase_q == 2'b00 && want && pre > PED_GREEN_CAP)
        zero_at = e + PED_GREEN_CAP;
      else
`endif
      if (pre == 0 && !strobed) begin
        m_adv   = 1'b1;
        strobed = 1'b1;
      end
    end
    ped_d3 = ped_d2;
    ped_d2 = ped_d1;
    ped_d1 = ped;
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_remaining"}, tpt.remaining, RED_TIME - 1);
    checkOutput({tag, "_advance"}, tpt.advance, 0);
    checkOutput({tag, "_pending"}, tpt.ped_pending, 0);
    checkOutput({tag, "_walk"}, tpt.walk, 0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    model_reset();
    fsm_phase = 2'b10;
    tpt.phase = 2'b10;
    prev_adv  = 1'b0;
    force_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Emulates the FSM: it steps on the edge after a strobe, so the timer sees the change one edge later.
  task automatic applyStimulus(input int cyc);
    if (prev_adv) fsm_phase = next_phase(fsm_phase);
    prev_adv = m_adv;

    if (cyc > 30 && force_cnt == 0 && $urandom_range(0, 199) == 0) force_cnt = 3;
    if (force_cnt > 0) begin
      tpt.phase = 2'b11;
      force_cnt--;
    end else begin
      tpt.phase = fsm_phase;
    end

    if (ped_cnt > 0) begin
      tpt.ped_req = 1'b1;
      ped_cnt--;
    end else begin
      tpt.ped_req = 1'b0;
      if (cyc > 30 && $urandom_range(0, 24) == 0) ped_cnt = $urandom_range(1, 4);
    end

    if (cyc > 30 && $urandom_range(0, 399) == 0) do_reset();
  endtask

  initial begin
    rst         = 1'b1;
    tpt.phase   = 2'b10;
    tpt.ped_req = 1'b0;
    fsm_phase   = 2'b10;
    prev_adv    = 1'b0;
    force_cnt   = 0;
    ped_cnt     = 0;
    first_seen  = 1'b0;
    edge_num    = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1 check_reset_values("reset");
    rst = 1'b0;

    for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
      @(posedge clk);
      model_step(tpt.phase, tpt.ped_req);
      #1;
      checkOutput("advance", tpt.advance, m_adv);
      checkOutput("remaining", tpt.remaining, rem_at(edge_num));
      checkOutput("ped_pending", tpt.ped_pending, m_pending);
      checkOutput("walk", tpt.walk, m_walk);
      if (!first_seen && tpt.advance) begin
        first_seen = 1'b1;
        checkOutput("first_adv_edge", cyc + 1, RED_TIME);
      end
      if (cyc == 40 && !first_seen) checkOutput("first_adv_edge", 0, RED_TIME);
      applyStimulus(cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
